verdict_serializer: RTL and testbench
=====================================

Name: verdict_serializer

Overview:
- Downstream consumer of the generated RTLola monitor (topEntity).
- Every cycle in which any output's aktv flag is high, it captures the active-output mask, all output values and a cycle timestamp into a record FIFO.
- It drains each record as a word stream with valid/ready handshake: a header word, then one word per active output, lowest index first.
- It feeds the host/UART/trace link, so verdicts survive backpressure instead of being lost the way single-cycle aktv pulses would be.

Parameters:
- NUM_OUT, 11, number of monitor outputs (1..16).
- DATA_W, 64, width of each output value and of out_data; narrower outputs (bool, bit) are zero-extended by the instantiating wrapper.
- DEPTH, 4, record FIFO depth (power of two, >=2).
- TS_W, DATA_W-NUM_OUT, timestamp width carried in the header.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  global enable; same meaning as the monitor's en.
- out_vals  in  NUM_OUT*DATA_W  monitor outputs concatenated; output k at bits [k*DATA_W +: DATA_W].
- aktv  in  NUM_OUT  monitor output_k_aktv flags, bit k = output k.
- out_data  out  DATA_W  stream word.
- out_hdr  out  1  current word is a header.
- out_last  out  1  current word is the last word of its record.
- out_valid  out  1  word valid.
- out_ready  in  1  sink accepts the word.
- overflow  out  1  sticky: at least one record dropped since reset.
- fifo_level  out  $clog2(DEPTH)+1  records currently stored.

Behaviour:
- Reset (rst==0 sampled at a rising edge): out_valid=0, out_hdr=0, out_last=0, out_data=0, overflow=0, fifo_level=0, timestamp=0, FSM=IDLE. This applies mid-record too; any partial record is discarded.
- en==0: no capture, timestamp frozen, FSM and all registers hold, outputs held. A handshake is not completed even if out_ready==1.
- Timestamp:
  - TS_W-bit counter, +1 on every enabled cycle after reset; wraps to 0 silently.
  - The value sampled on a capture edge is the one stored.
- Capture:
  - At each enabled edge with |aktv, push {ts, aktv, out_vals}.
  - aktv==0 never pushes.
- FIFO:
  - fifo_level counts stored records.
  - Full and a push with no pop in the same cycle: record dropped, overflow<=1.
  - Full with push and pop in the same cycle: both succeed, no drop.
  - Empty with push in the same cycle: record becomes poppable next cycle (no bypass).
- FSM states are IDLE, HDR and DATA.
  - IDLE: if FIFO not empty, pop into the holding register (ts, mask, vals), go HDR. out_valid=0.
  - HDR: out_valid=1, out_hdr=1, out_data={ts, mask} (mask in low NUM_OUT bits). On out_valid&&out_ready, go DATA with idx = lowest set bit of mask.
  - DATA:
    - out_valid=1, out_hdr=0, out_data=vals[idx].
    - out_last=1 iff no set mask bit remains above idx.
    - On a handshake, clear mask bit idx. If the mask is now zero go IDLE, else set idx to the next set bit.
- Registered outputs; out_data/out_hdr/out_last stay stable while out_valid && !out_ready (AXI-stream rule). out_valid never drops without a handshake except on reset.
- Latency:
  - Capture at edge N with FIFO empty and FSM IDLE: header valid after edge N+2.
  - A full record occupies 1+popcount(mask) beats plus one IDLE bubble.
- Signed values pass bit-exact (two's complement); no arithmetic on values.

Optional Feature:
- Macro: VERDICT_SER_DROP_CNT_EN.
- Defined:
  - Adds output drop_count (16 bits): saturating count of dropped records. It holds at 16'hFFFF and resets to 0.
  - When a record is dropped, the next header emitted has bit DATA_W-1 set. That bit is reserved zero otherwise, and TS_W is reduced by 1.
- Undefined: no drop_count port; only sticky overflow; header MSB is timestamp.

Test Plan:
- Single record (NUM_OUT=11, DATA_W=64, DEPTH=4):
  - Stimulus: aktv=11'h011, out0=-20, out4=3, captured at ts=50, out_ready=1.
  - Required: header 64'(50<<11 | 11'h011) with out_hdr=1, then 64'hFFFFFFFFFFFFFFEC, then 3 with out_last=1; header valid exactly 2 edges after capture.
- Backpressure:
  - Stimulus: same record, out_ready=0 for 5 cycles in HDR and again in DATA.
  - Required: out_valid, out_data and flags constant during the stall; word order unchanged.
- Overflow:
  - Stimulus: out_ready=0, six consecutive cycles with aktv=11'h001.
  - Required: fifo_level=4 (FSM holds one more record, so four stored plus one in the holding register); overflow=1; drop_count=1 with macro.
  - Required: releasing ready yields exactly 5 records with consecutive timestamps.
- Full push+pop:
  - Stimulus: FIFO full, FSM in IDLE popping, aktv nonzero on the same edge.
  - Required: no drop, overflow stays 0, fifo_level stays 4.
- Reset mid-stream:
  - Stimulus: rst=0 while in DATA after the header was accepted.
  - Required: out_valid=0 after that edge, fifo_level=0, next capture header timestamp restarts from 1 cycle after rst release.
- Enable gating:
  - Stimulus: en=0 for 10 cycles with aktv=11'h7FF.
  - Required: nothing captured, timestamp unchanged, outputs frozen.

Source files
------------

// File: rtl/verdict_serializer.sv
// Buffers RTLola monitor verdicts as {timestamp, aktv mask, values} records and
// streams each one out as a header word plus one word per active output.
// Optional drop counter / header drop flag: define VERDICT_SER_DROP_CNT_EN.
module verdict_serializer #(
    parameter int NUM_OUT = 11,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_OUT*DATA_W-1:0]   out_vals,
    input  logic [NUM_OUT-1:0]          aktv,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_hdr,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overflow,
    output logic [$clog2(DEPTH):0]      fifo_level
`ifdef VERDICT_SER_DROP_CNT_EN
    ,
    output logic [15:0]                 drop_count
`endif
);

`ifdef VERDICT_SER_DROP_CNT_EN
    localparam int FLAG_W = 1;
`else
    localparam int FLAG_W = 0;
`endif
    localparam int TS_W  = DATA_W - NUM_OUT - FLAG_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int VAL_W = NUM_OUT * DATA_W;
    localparam int REC_W = TS_W + NUM_OUT + VAL_W;

    // state | meaning
    // IDLE  | no word on the stream; pops the next record when one is visible
    // HDR   | presenting the header word of the held record
    // DATA  | presenting the value of output idx_q of the held record
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t             state_q, state_d;
    logic [NUM_OUT-1:0] mask_q, mask_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]   vals_q, vals_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_hdr_q, out_hdr_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;
    logic               overflow_q;
    logic [TS_W-1:0]    ts_q;

    logic [REC_W-1:0]   mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, rd_ptr_q, wr_vis_q;
    logic [AW:0]        level_w;
    logic               full_w, rd_avail_w, push_w, pop_w, do_write_w, drop_w;
    logic [REC_W-1:0]   rd_rec_w;
    logic [VAL_W-1:0]   rd_vals_w;
    logic [NUM_OUT-1:0] rd_mask_w;
    logic [TS_W-1:0]    rd_ts_w;
    logic [NUM_OUT-1:0] rem_w;
    logic [IW-1:0]      sel_w;

    function automatic logic [IW-1:0] lowest_bit(input logic [NUM_OUT-1:0] m);
        lowest_bit = '0;
        for (int k = NUM_OUT - 1; k >= 0; k--) begin
            if (m[k]) lowest_bit = IW'(k);
        end
    endfunction

    function automatic logic none_above(input logic [NUM_OUT-1:0] m, input logic [IW-1:0] i);
        none_above = ((m & ~(NUM_OUT'(1) << i)) == '0);
    endfunction

    assign level_w    = wr_ptr_q - rd_ptr_q;
    assign full_w     = (level_w == (AW+1)'(DEPTH));
    // The read side sees writes one cycle late, so a fresh record is never bypassed.
    assign rd_avail_w = (rd_ptr_q != wr_vis_q);
    assign push_w     = en & (|aktv);
    assign do_write_w = push_w & (~full_w | pop_w);
    assign drop_w     = push_w & full_w & ~pop_w;

    assign rd_rec_w   = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_vals_w  = rd_rec_w[VAL_W-1:0];
    assign rd_mask_w  = rd_rec_w[VAL_W +: NUM_OUT];
    assign rd_ts_w    = rd_rec_w[REC_W-1 -: TS_W];
    assign rem_w      = mask_q & ~(NUM_OUT'(1) << idx_q);

`ifdef VERDICT_SER_DROP_CNT_EN
    logic        drop_pend_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_pend_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else if (en) begin
            if (drop_w)     drop_pend_q <= 1'b1;
            else if (pop_w) drop_pend_q <= 1'b0;
            if (drop_w && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        vals_d      = vals_q;
        out_data_d  = out_data_q;
        out_hdr_d   = out_hdr_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        pop_w       = 1'b0;
        sel_w       = '0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (rd_avail_w) begin
                        pop_w       = 1'b1;
                        mask_d      = rd_mask_w;
                        vals_d      = rd_vals_w;
`ifdef VERDICT_SER_DROP_CNT_EN
                        out_data_d  = {drop_pend_q, rd_ts_w, rd_mask_w};
`else
                        out_data_d  = {rd_ts_w, rd_mask_w};
`endif
                        out_hdr_d   = 1'b1;
                        out_last_d  = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = HDR;
                    end
                end
                HDR: begin
                    if (out_ready) begin
                        sel_w      = lowest_bit(mask_q);
                        idx_d      = sel_w;
                        out_data_d = vals_q[int'(sel_w)*DATA_W +: DATA_W];
                        out_hdr_d  = 1'b0;
                        out_last_d = none_above(mask_q, sel_w);
                        state_d    = DATA;
                    end
                end
                DATA: begin
                    if (out_ready) begin
                        mask_d = rem_w;
                        if (rem_w == '0) begin
                            out_data_d  = '0;
                            out_hdr_d   = 1'b0;
                            out_last_d  = 1'b0;
                            out_valid_d = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            sel_w      = lowest_bit(rem_w);
                            idx_d      = sel_w;
                            out_data_d = vals_q[int'(sel_w)*DATA_W +: DATA_W];
                            out_last_d = none_above(rem_w, sel_w);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            idx_q       <= '0;
            vals_q      <= '0;
            out_data_q  <= '0;
            out_hdr_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            ts_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_vis_q    <= '0;
        end else if (en) begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            vals_q      <= vals_d;
            out_data_q  <= out_data_d;
            out_hdr_q   <= out_hdr_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            ts_q        <= ts_q + TS_W'(1);
            wr_vis_q    <= wr_ptr_q;
            if (do_write_w) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_w)      rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (drop_w)     overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write_w) mem_q[wr_ptr_q[AW-1:0]] <= {ts_q, aktv, out_vals};
    end

    assign out_data   = out_data_q;
    assign out_hdr    = out_hdr_q;
    assign out_last   = out_last_q;
    assign out_valid  = out_valid_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_w;

endmodule

// File: tb/tb_verdict_serializer.sv
// Directed bench for verdict_serializer: a record-level model predicts every
// stream word, fifo_level and overflow; literal checks pin the model.
module tb_verdict_serializer;
    localparam int NUM_OUT = 11;
    localparam int DATA_W  = 64;
    localparam int DEPTH   = 4;
    localparam int TS_W    = DATA_W - NUM_OUT;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam logic [63:0] TS_MASK = (64'd1 << TS_W) - 64'd1;

    logic                      clk = 1'b0;
    logic                      rst, en, out_ready;
    logic [NUM_OUT*DATA_W-1:0] out_vals;
    logic [NUM_OUT-1:0]        aktv;
    logic [DATA_W-1:0]         out_data;
    logic                      out_hdr, out_last, out_valid, overflow;
    logic [LW-1:0]             fifo_level;
`ifdef VERDICT_SER_DROP_CNT_EN
    logic [15:0]               drop_count;
`endif

    always #5 clk = ~clk;

    verdict_serializer #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .out_vals(out_vals), .aktv(aktv),
        .out_data(out_data), .out_hdr(out_hdr), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
`ifdef VERDICT_SER_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .fifo_level(fifo_level)
    );

    typedef struct { logic [DATA_W-1:0] data; bit hdr; bit last; } word_t;
    typedef struct { logic [63:0] ts; logic [NUM_OUT-1:0] mask; logic [NUM_OUT*DATA_W-1:0] vals; int edge_no; } rec_t;

    rec_t  fifo_m[$];
    word_t hold_m[$];
    rec_t  r_m;
    logic [63:0] ts_m = '0;
    bit    ov_m = 1'b0;
    int    edge_cnt = 0;
    int    top_m;
    bit    chk_en = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    hdr_seen = 0;
    int    hdr_base;

    // Record-level model: a record becomes poppable two enabled edges after capture,
    // the stream resumes one cycle after a record's last word, FIFO holds DEPTH.
    initial forever begin
        @(posedge clk);
        if (rst !== 1'b1) begin
            fifo_m.delete();
            hold_m.delete();
            ov_m = 1'b0;
            ts_m = '0;
        end else if (en) begin
            if (hold_m.size() != 0) begin
                if (out_ready) hold_m.delete(0);
            end else if (fifo_m.size() != 0 && fifo_m[0].edge_no + 2 <= edge_cnt) begin
                r_m = fifo_m.pop_front();
                hold_m.push_back('{data: ((r_m.ts & TS_MASK) << NUM_OUT) | 64'(r_m.mask), hdr: 1'b1, last: 1'b0});
                top_m = -1;
                for (int k = 0; k < NUM_OUT; k++) if (r_m.mask[k]) top_m = k;
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (r_m.mask[k])
                        hold_m.push_back('{data: r_m.vals[k*DATA_W +: DATA_W], hdr: 1'b0, last: (k == top_m)});
                end
            end
            if (|aktv) begin
                if (fifo_m.size() == DEPTH) ov_m = 1'b1;
                else fifo_m.push_back('{ts: ts_m, mask: aktv, vals: out_vals, edge_no: edge_cnt});
            end
            ts_m = (ts_m + 64'd1) & TS_MASK;
            edge_cnt++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_checks++;
            if (hold_m.size() != 0) begin
                if (out_valid !== 1'b1 || out_data !== hold_m[0].data ||
                    out_hdr !== hold_m[0].hdr || out_last !== hold_m[0].last) begin
                    n_errors++;
                    $display("FAIL stream t=%0t: got valid=%b data=%h hdr=%b last=%b, required valid=1 data=%h hdr=%b last=%b",
                             $time, out_valid, out_data, out_hdr, out_last, hold_m[0].data, hold_m[0].hdr, hold_m[0].last);
                end
            end else if (out_valid !== 1'b0 || out_hdr !== 1'b0 || out_last !== 1'b0) begin
                n_errors++;
                $display("FAIL idle t=%0t: got valid=%b hdr=%b last=%b, required all 0", $time, out_valid, out_hdr, out_last);
            end
            n_checks++;
            if (fifo_level !== LW'(fifo_m.size()) || overflow !== ov_m) begin
                n_errors++;
                $display("FAIL status t=%0t: got level=%0d overflow=%b, required level=%0d overflow=%b",
                         $time, fifo_level, overflow, fifo_m.size(), ov_m);
            end
            if (rst && en && out_valid && out_ready && out_hdr) hdr_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; aktv = '0; out_ready = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) out_vals[k*DATA_W +: DATA_W] = 64'hA5A5_0000_0000_0000 + 64'(k);
        out_vals[0*DATA_W +: DATA_W] = -64'sd20;
        out_vals[4*DATA_W +: DATA_W] = 64'd3;
        tick(2);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_hdr", 64'(out_hdr), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        rst = 1'b1;
        chk_en = 1'b1;

        // single record captured at ts=50
        out_ready = 1'b1;
        tick(50);
        aktv = 11'h011;
        tick(1);
        aktv = '0;
        chk("lat_n0_valid", 64'(out_valid), 64'd0);
        tick(1);
        chk("lat_n1_valid", 64'(out_valid), 64'd0);
        tick(1);
        chk("lat_n2_valid", 64'(out_valid), 64'd1);
        chk("single_hdr_data", out_data, 64'd102417);
        chk("single_hdr_flag", 64'(out_hdr), 64'd1);
        tick(1);
        chk("single_w0", out_data, 64'hFFFF_FFFF_FFFF_FFEC);
        chk("single_w0_last", 64'(out_last), 64'd0);
        tick(1);
        chk("single_w1", out_data, 64'd3);
        chk("single_w1_last", 64'(out_last), 64'd1);
        tick(1);
        chk("single_done", 64'(out_valid), 64'd0);

        // backpressure, including en=0 while ready is high
        out_ready = 1'b0;
        aktv = 11'h011;
        tick(1);
        aktv = '0;
        tick(2);
        tick(5);
        en = 1'b0; out_ready = 1'b1;
        tick(2);
        chk("bp_hdr_held", 64'(out_hdr), 64'd1);
        en = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(5);
        chk("bp_w0_held", out_data, 64'hFFFF_FFFF_FFFF_FFEC);
        out_ready = 1'b1;
        tick(1);
        chk("bp_w1", out_data, 64'd3);
        chk("bp_w1_last", 64'(out_last), 64'd1);
        tick(2);

        // overflow: six captures with the sink stalled
        rst = 1'b0; tick(1); rst = 1'b1;
        out_ready = 1'b0;
        aktv = 11'h001;
        tick(6);
        aktv = '0;
        chk("ovf_level", 64'(fifo_level), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        hdr_base = hdr_seen;
        out_ready = 1'b1;
        tick(30);
        chk("ovf_records", 64'(hdr_seen - hdr_base), 64'd5);

        // full FIFO with simultaneous pop and push
        rst = 1'b0; tick(1); rst = 1'b1;
        out_ready = 1'b0;
        aktv = 11'h001;
        tick(5);
        aktv = '0;
        chk("pp_full", 64'(fifo_level), 64'd4);
        out_ready = 1'b1;
        tick(2);
        out_ready = 1'b0;
        aktv = 11'h001;
        tick(1);
        aktv = '0;
        chk("pp_level", 64'(fifo_level), 64'd4);
        chk("pp_overflow", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        tick(30);

        // reset while a record is mid-stream
        out_ready = 1'b0;
        aktv = 11'h011;
        tick(1);
        aktv = 11'h001;
        tick(2);
        aktv = '0;
        chk("rm_hdr_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("rm_in_data", 64'(out_hdr), 64'd0);
        rst = 1'b0;
        tick(1);
        chk("rm_valid", 64'(out_valid), 64'd0);
        chk("rm_level", 64'(fifo_level), 64'd0);
        rst = 1'b1;
        tick(3);
        aktv = 11'h002;
        tick(1);
        aktv = '0;
        out_ready = 1'b1;
        tick(2);
        chk("rm_new_hdr", out_data, 64'd6146);
        chk("rm_new_hdr_flag", 64'(out_hdr), 64'd1);
        tick(5);

        // enable gating
        rst = 1'b0; tick(1); rst = 1'b1;
        tick(5);
        en = 1'b0;
        aktv = 11'h7FF;
        tick(10);
        chk("en_level", 64'(fifo_level), 64'd0);
        chk("en_valid", 64'(out_valid), 64'd0);
        en = 1'b1;
        aktv = 11'h001;
        tick(1);
        aktv = '0;
        tick(2);
        chk("en_ts_hdr", out_data, 64'd10241);
        tick(5);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
